// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the 4-stage pipeline. Holds the PC, reads a locally programmed
// instruction store (2**ADDR_W x INSTR_W), and issues words to decode over a
// valid/ready handshake. Opcode 2'b11 (jump) is resolved here: when a jump word
// is transferred the PC is redirected to its target and one bubble is inserted.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset (control state only, not store)
//   prog_we      store write enable, honoured only while idle
//   prog_addr    store write address
//   prog_data    store write data
//   start        begin fetching from address 0 (sampled while idle)
//   stop         abort fetching and return to idle
//   instr_out    issued instruction word
//   instr_valid  instr_out / pc_out valid
//   instr_ready  decode stage accepts; transfer = valid & ready
//   pc_out       address of instr_out
//   jump_taken   one-cycle pulse the cycle after a jump transfer
//   busy         high while fetching (RUN or FLUSH)
//   jump_count   (only with IFU_JUMP_COUNT_EN) saturating count of jump
//                transfers since the last start
//
// Build option: define IFU_JUMP_COUNT_EN to add the jump_count output.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               stop,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               jump_taken,
  output logic               busy
`ifdef IFU_JUMP_COUNT_EN
  ,
  output logic [15:0]        jump_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic                 valid_q, valid_d;
  logic                 jump_q, jump_d;
  logic [INSTR_W-1:0]   instr_q;
  logic                 fetch;
  logic                 xfer;
  logic                 jump_xfer;
  logic                 mem_we;

  // Instruction store: no reset, so contents survive rst_n.
  logic [INSTR_W-1:0]   mem [2**ADDR_W];

  assign xfer      = valid_q && instr_ready;
  assign jump_xfer = xfer && (instr_q[INSTR_W-1 -: 2] == 2'b11);
  assign mem_we    = prog_we && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // The output word register doubles as the store's registered read port.
  // It only loads when the pipeline can advance, so under backpressure the
  // PC and the presented word both hold and nothing needs a skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (fetch) begin
      instr_q <= mem[pc_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    jump_d   = jump_xfer;
    fetch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start && !stop) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN, S_FLUSH: begin
        if (stop) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (jump_xfer) begin
          // The word that would have been fetched this cycle is sequential
          // and must never be issued: skip the read and redirect instead.
          state_d = S_FLUSH;
          pc_d    = instr_q[ADDR_W-1:0];
          valid_d = 1'b0;
        end else if (!valid_q || instr_ready) begin
          fetch    = 1'b1;
          state_d  = S_RUN;
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          pc_d     = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      jump_q   <= jump_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign jump_taken  = jump_q;
  assign busy        = (state_q != S_IDLE);

`ifdef IFU_JUMP_COUNT_EN
  logic [15:0] jump_count_q, jump_count_d;

  always_comb begin
    jump_count_d = jump_count_q;
    if (state_q == S_IDLE && start && !stop) begin
      jump_count_d = '0;
    end else if (jump_xfer && jump_count_q != 16'hFFFF) begin
      jump_count_d = jump_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_count_q <= '0;
    end else begin
      jump_count_q <= jump_count_d;
    end
  end

  assign jump_count = jump_count_q;
`endif

endmodule
